// File: rtl/frame_out_loader.sv
// rtl/frame_out_loader.sv - captures result words and serialises them as a header/data/checksum frame
module frame_out_loader #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 2,
    parameter int OUT_W   = 8,
    parameter int MODE_W  = 3,
    parameter int HDR_EN  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MODE_W-1:0]          mode,
    input  logic [N_WORDS*WORD_W-1:0]  words,
    input  logic                       hold,
    output logic                       busy,
    output logic [OUT_W-1:0]           out_byte,
    output logic                       out_valid,
    output logic                       out_last,
    output logic                       done
);

    localparam int CHUNKS = WORD_W / OUT_W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int WW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [MODE_W-1:0]           mode_q, mode_d;
    logic [N_WORDS*WORD_W-1:0]   words_q, words_d;
    logic [OUT_W-1:0]            csum_q, csum_d;
    logic [WW-1:0]               word_q, word_d;
    logic [CW-1:0]               chunk_q, chunk_d;
    logic                        done_q, done_d;

    logic [WORD_W-1:0]           cur_word;
    logic [OUT_W-1:0]            data_beat;
    logic [OUT_W-1:0]            hdr_beat;
    logic [OUT_W-1:0]            beat;
    logic                        accept;

    // Beat selection: header from captured mode, data chunk MS-first within the current word
    always_comb begin
        cur_word  = '0;
        data_beat = '0;
        hdr_beat  = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (word_q == WW'(i)) begin
                cur_word = words_q[i*WORD_W +: WORD_W];
            end
        end
        for (int k = 0; k < CHUNKS; k++) begin
            if (chunk_q == CW'(k)) begin
                data_beat = cur_word[(CHUNKS-1-k)*OUT_W +: OUT_W];
            end
        end
        hdr_beat[OUT_W-1]    = 1'b1;
        hdr_beat[MODE_W-1:0] = mode_q;
        case (state_q)
            HDR:     beat = hdr_beat;
            DATA:    beat = data_beat;
            CSUM:    beat = csum_q;
            default: beat = '0;
        endcase
    end

    assign accept    = (state_q != IDLE) && !hold;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q != IDLE);
    assign out_last  = (state_q == CSUM);
    assign out_byte  = beat;
    assign done      = done_q;

    // Next-state logic: capture on start in IDLE, advance one beat per accepted cycle
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        words_d = words_q;
        csum_d  = csum_q;
        word_d  = word_q;
        chunk_d = chunk_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    words_d = words;
                    csum_d  = '0;
                    word_d  = '0;
                    chunk_d = '0;
                    state_d = (HDR_EN != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                if (accept) begin
                    csum_d  = csum_q ^ beat;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ beat;
                    if (chunk_q == CW'(CHUNKS-1)) begin
                        chunk_d = '0;
                        if (word_q == WW'(N_WORDS-1)) begin
                            word_d  = '0;
                            state_d = CSUM;
                        end else begin
                            word_d = word_q + WW'(1);
                        end
                    end else begin
                        chunk_d = chunk_q + CW'(1);
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            words_q <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            chunk_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            words_q <= words_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            chunk_q <= chunk_d;
            done_q  <= done_d;
        end
    end

endmodule
